// File: rtl/cpu_sequencer.sv
// Multi-cycle instruction sequencer for the 12-bit CPU: fetches over a REQ/VALID
// handshake, decodes into ALU function select and register addresses, handles JMP/HALT.
//
// state     | meaning
// ----------+---------------------------------------------------------
// IDLE      | after reset, waiting for run
// FETCH     | imem_req high, waiting for imem_valid to capture IR
// DECODE    | ALU op: latch fs/addresses; JMP: load PC; HALT: stop
// EXECUTE   | one cycle of ALU settling with fs/addresses stable
// WRITEBACK | wr_en pulse, PC+1, retire
// HALT      | halted high until run restarts from PC 0
module cpu_sequencer #(
  parameter int ADDR_W = 8,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              run,
  output logic [ADDR_W-1:0] imem_addr,
  output logic              imem_req,
  input  logic              imem_valid,
  input  logic [11:0]       imem_data,
  output logic [2:0]        fs,
  output logic [2:0]        ra_addr,
  output logic [2:0]        rb_addr,
  output logic [2:0]        wr_addr,
  output logic              wr_en,
  output logic              busy,
  output logic              halted,
  output logic [CNT_W-1:0]  insn_count
);

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_DECODE, S_EXECUTE, S_WRITEBACK, S_HALT
  } state_t;

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] pc;
  logic [11:0]       ir;
  logic [2:0]        op;
  logic              is_jmp, is_halt;
  logic [ADDR_W-1:0] jmp_target;
  logic [CNT_W-1:0]  count_inc;

  assign op        = ir[11:9];
  assign is_jmp    = (op == 3'b111) && !ir[8];
  assign is_halt   = (op == 3'b111) && ir[8];
  assign imem_addr = pc;
  assign count_inc = (insn_count == '1) ? insn_count : insn_count + CNT_W'(1);

  // Jump target is the low address bits of IR, zero-extended for wide PCs.
  generate
    if (ADDR_W > 8) begin : g_wide_pc
      assign jmp_target = {{(ADDR_W-8){1'b0}}, ir[7:0]};
    end else begin : g_narrow_pc
      assign jmp_target = ir[ADDR_W-1:0];
    end
  endgenerate

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= S_IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:      if (run) state_nxt = S_FETCH;
      S_FETCH:     if (imem_valid) state_nxt = S_DECODE;
      S_DECODE: begin
        if (is_halt)     state_nxt = S_HALT;
        else if (is_jmp) state_nxt = S_FETCH;
        else             state_nxt = S_EXECUTE;
      end
      S_EXECUTE:   state_nxt = S_WRITEBACK;
      S_WRITEBACK: state_nxt = S_FETCH;
      S_HALT:      if (run) state_nxt = S_FETCH;
      default:     state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    imem_req = 1'b0;
    wr_en    = 1'b0;
    busy     = 1'b0;
    halted   = 1'b0;
    case (state)
      S_FETCH:     begin imem_req = 1'b1; busy = 1'b1; end
      S_DECODE:    busy = 1'b1;
      S_EXECUTE:   busy = 1'b1;
      S_WRITEBACK: begin wr_en = 1'b1; busy = 1'b1; end
      S_HALT:      halted = 1'b1;
      default:     ;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pc         <= '0;
      ir         <= '0;
      fs         <= '0;
      ra_addr    <= '0;
      rb_addr    <= '0;
      wr_addr    <= '0;
      insn_count <= '0;
    end else begin
      case (state)
        S_IDLE, S_HALT: begin
          if (run) begin
            pc         <= '0;
            insn_count <= '0;
          end
        end
        S_FETCH: if (imem_valid) ir <= imem_data;
        S_DECODE: begin
          if (op != 3'b111) begin
            fs      <= op;
            ra_addr <= ir[5:3];
            rb_addr <= ir[2:0];
            wr_addr <= ir[8:6];
          end else begin
            insn_count <= count_inc;
            if (!ir[8]) pc <= jmp_target;
          end
        end
        S_WRITEBACK: begin
          pc         <= pc + ADDR_W'(1);
          insn_count <= count_inc;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_cpu_sequencer.sv
// Self-checking bench for cpu_sequencer: directed program steps followed by a random
// program, each instruction checked against an ISA-level model of PC, count and decode.
module tb_cpu_sequencer;
  localparam int ADDR_W  = 8;
  localparam int CNT_W   = 4;  // narrow counter so saturation is reachable quickly
  localparam int PC_MASK = (1 << ADDR_W) - 1;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  logic              clk = 1'b0;
  logic              reset_n, run, imem_req, imem_valid, wr_en, busy, halted;
  logic [ADDR_W-1:0] imem_addr;
  logic [11:0]       imem_data;
  logic [2:0]        fs, ra_addr, rb_addr, wr_addr;
  logic [CNT_W-1:0]  insn_count;

  always #5 clk = ~clk;

  cpu_sequencer #(.ADDR_W(ADDR_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset_n(reset_n), .run(run),
    .imem_addr(imem_addr), .imem_req(imem_req), .imem_valid(imem_valid),
    .imem_data(imem_data), .fs(fs), .ra_addr(ra_addr), .rb_addr(rb_addr),
    .wr_addr(wr_addr), .wr_en(wr_en), .busy(busy), .halted(halted),
    .insn_count(insn_count)
  );

  logic [11:0] mem [256];
  int checks = 0;
  int failures = 0;

  // Architectural model: program counter, retired count, last ALU decode, halt flag.
  int       m_pc, m_cnt;
  logic [2:0] m_fs, m_ra, m_rb, m_wr;
  bit       m_halted;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic model_reset();
    m_pc = 0; m_cnt = 0; m_halted = 0;
    m_fs = 0; m_ra = 0; m_rb = 0; m_wr = 0;
  endtask

  task automatic retire();
    m_cnt = (m_cnt == CNT_MAX) ? CNT_MAX : m_cnt + 1;
  endtask

  task automatic chk_reset_values(input string tag);
    chk({tag, "_addr"},   imem_addr, 0);
    chk({tag, "_req"},    imem_req, 0);
    chk({tag, "_fs"},     fs, 0);
    chk({tag, "_ra"},     ra_addr, 0);
    chk({tag, "_rb"},     rb_addr, 0);
    chk({tag, "_wr"},     wr_addr, 0);
    chk({tag, "_wr_en"},  wr_en, 0);
    chk({tag, "_busy"},   busy, 0);
    chk({tag, "_halted"}, halted, 0);
    chk({tag, "_count"},  insn_count, 0);
  endtask

  // Called at a negedge with the DUT in FETCH; runs one instruction to its end.
  task automatic do_insn(input int waits, input bit noise);
    logic [11:0] w;
    w = mem[m_pc];
    chk("fetch_req", imem_req, 1);
    chk("fetch_addr", imem_addr, m_pc);
    chk("fetch_busy", busy, 1);
    for (int i = 0; i < waits; i++) begin
      imem_valid = 1'b0;
      run = noise;
      tick();
      chk("wait_req", imem_req, 1);
      chk("wait_addr", imem_addr, m_pc);
    end
    imem_valid = 1'b1;
    imem_data = w;
    run = noise;
    tick();
    imem_valid = noise;
    imem_data = 12'($urandom);
    chk("decode_wr_en", wr_en, 0);
    chk("decode_busy", busy, 1);
    if (w[11:9] != 3'b111) begin
      tick();
      m_fs = w[11:9]; m_wr = w[8:6]; m_ra = w[5:3]; m_rb = w[2:0];
      chk("exec_fs", fs, m_fs);
      chk("exec_ra", ra_addr, m_ra);
      chk("exec_rb", rb_addr, m_rb);
      chk("exec_wr_addr", wr_addr, m_wr);
      chk("exec_wr_en", wr_en, 0);
      tick();
      chk("wb_wr_en", wr_en, 1);
      chk("wb_fs", fs, m_fs);
      chk("wb_busy", busy, 1);
      tick();
      m_pc = (m_pc + 1) & PC_MASK;
      retire();
      chk("alu_next_wr_en", wr_en, 0);
      chk("alu_next_req", imem_req, 1);
      chk("alu_next_pc", imem_addr, m_pc);
      chk("alu_count", insn_count, m_cnt);
    end else if (!w[8]) begin
      tick();
      m_pc = w[7:0];
      retire();
      chk("jmp_req", imem_req, 1);
      chk("jmp_pc", imem_addr, m_pc);
      chk("jmp_count", insn_count, m_cnt);
      chk("jmp_wr_en", wr_en, 0);
      chk("jmp_fs_hold", fs, m_fs);
    end else begin
      tick();
      retire();
      m_halted = 1;
      chk("halt_halted", halted, 1);
      chk("halt_busy", busy, 0);
      chk("halt_req", imem_req, 0);
      chk("halt_wr_en", wr_en, 0);
      chk("halt_pc", imem_addr, m_pc);
      chk("halt_count", insn_count, m_cnt);
      chk("halt_fs_hold", fs, m_fs);
    end
    imem_valid = 1'b0;
    run = 1'b0;
  endtask

  task automatic restart();
    run = 1'b1;
    tick();
    run = 1'b0;
    m_pc = 0; m_cnt = 0; m_halted = 0;
    chk("restart_halted", halted, 0);
    chk("restart_req", imem_req, 1);
    chk("restart_pc", imem_addr, 0);
    chk("restart_count", insn_count, 0);
  endtask

  initial begin
    logic [11:0] w;
    reset_n = 1'b0; run = 1'b0; imem_valid = 1'b0; imem_data = '0;
    for (int i = 0; i < 256; i++) mem[i] = '0;
    model_reset();
    #3;
    chk_reset_values("por");
    @(negedge clk);
    reset_n = 1'b1;
    tick(); tick();
    chk("idle_req", imem_req, 0);
    chk("idle_busy", busy, 0);

    // ADD then HALT with zero-wait memory.
    mem[0] = 12'h0D1;
    mem[1] = 12'hF00;
    restart();
    do_insn(0, 0);
    do_insn(0, 0);

    // SUB..OR program, first fetch delayed 3 cycles, RUN and stray VALID noise while busy.
    for (int k = 0; k < 6; k++) begin
      w = {3'(k + 1), 9'($urandom)};
      mem[k] = w;
    end
    mem[6] = 12'hF00;
    restart();
    do_insn(3, 1);
    for (int k = 1; k < 7; k++) do_insn(0, 1);
    chk("prog_halted", halted, 1);

    // HALT holds without RUN even with VALID toggling.
    imem_valid = 1'b1;
    tick();
    imem_valid = 1'b0;
    chk("halt_hold", halted, 1);

    // JMP to 0xFF, ADD there wraps PC to 0.
    mem[0]    = 12'hEFF;
    mem[8'hFF] = 12'h0D1;
    restart();
    do_insn(0, 0);
    do_insn(1, 0);
    chk("wrap_pc", imem_addr, 0);

    // Asynchronous reset in FETCH with REQ high.
    chk("pre_reset_req", imem_req, 1);
    #2;
    reset_n = 1'b0;
    #1;
    model_reset();
    chk_reset_values("async");
    @(negedge clk);
    reset_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("post_reset_req", imem_req, 0);
      chk("post_reset_busy", busy, 0);
    end

    // Random program: mostly ALU ops, some jumps and halts.
    for (int i = 0; i < 256; i++) begin
      int r;
      r = $urandom_range(0, 99);
      if (r < 80)      w = {3'($urandom_range(0, 6)), 9'($urandom)};
      else if (r < 92) w = {4'b1110, 8'($urandom)};
      else             w = {4'b1111, 8'($urandom)};
      mem[i] = w;
    end
    restart();
    for (int i = 0; i < 300; i++) begin
      if (m_halted) begin
        int idle;
        idle = $urandom_range(0, 3);
        for (int j = 0; j < idle; j++) begin
          imem_valid = 1'($urandom);
          imem_data = 12'($urandom);
          tick();
          chk("rand_halt_hold", halted, 1);
        end
        imem_valid = 1'b0;
        restart();
      end
      do_insn($urandom_range(0, 3), 1'($urandom));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
